// File: rtl/wb_regfile.sv
// Writeback stage and architectural register file, fed by the MEM/WB register.
// It selects the writeback data (load data or ALU result) and commits it to the
// register file. The two ID read ports bypass the write in the same cycle.
// It also generates the EX-stage forwarding selects and counts committed writes.
module wb_regfile #(
    parameter int NREG = 32,
    parameter int DW   = 32,
    parameter int CNTW = 32,
    localparam int AW  = $clog2(NREG)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            MemtoReg_i,
    input  logic            RegWrite_i,
    input  logic [DW-1:0]   ReadData_i,
    input  logic [DW-1:0]   ALU_i,
    input  logic [AW-1:0]   WBReg_i,
    input  logic [AW-1:0]   RSaddr_i,
    input  logic [AW-1:0]   RTaddr_i,
    output logic [DW-1:0]   RSdata_o,
    output logic [DW-1:0]   RTdata_o,
    output logic [DW-1:0]   WBdata_o,
    input  logic            EXMEM_RegWrite_i,
    input  logic [AW-1:0]   EXMEM_Rd_i,
    input  logic [AW-1:0]   IDEX_Rs_i,
    input  logic [AW-1:0]   IDEX_Rt_i,
    output logic [1:0]      ForwardA_o,
    output logic [1:0]      ForwardB_o,
    output logic [CNTW-1:0] WrCount_o
);

    localparam logic [1:0] FWD_REGFILE = 2'b00;
    localparam logic [1:0] FWD_MEMWB   = 2'b01;
    localparam logic [1:0] FWD_EXMEM   = 2'b10;

    logic [DW-1:0]   regs_q [NREG];
    logic [DW-1:0]   regs_d [NREG];
    logic [CNTW-1:0] cnt_q;
    logic [CNTW-1:0] cnt_d;
    logic            wb_wr_en;

    assign WBdata_o  = MemtoReg_i ? ReadData_i : ALU_i;
    assign wb_wr_en  = RegWrite_i && (WBReg_i != '0);
    assign WrCount_o = cnt_q;

    // Next register-file contents and counter: writes to r0 are dropped entirely.
    always_comb begin
        regs_d = regs_q;
        cnt_d  = cnt_q;
        if (wb_wr_en) begin
            regs_d[WBReg_i] = WBdata_o;
            cnt_d           = cnt_q + CNTW'(1);
        end
    end

    // State update; reset clears everything and suppresses a coincident write.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
            cnt_q <= '0;
        end else begin
            regs_q <= regs_d;
            cnt_q  <= cnt_d;
        end
    end

    // Read ports: r0 is hardwired to zero, otherwise the pending write bypasses the array.
    always_comb begin
        RSdata_o = '0;
        RTdata_o = '0;
        if (RSaddr_i != '0) begin
            RSdata_o = (wb_wr_en && (WBReg_i == RSaddr_i)) ? WBdata_o : regs_q[RSaddr_i];
        end
        if (RTaddr_i != '0) begin
            RTdata_o = (wb_wr_en && (WBReg_i == RTaddr_i)) ? WBdata_o : regs_q[RTaddr_i];
        end
    end

    // EX forwarding selects: the newer EX/MEM result takes priority over MEM/WB.
    always_comb begin
        ForwardA_o = FWD_REGFILE;
        ForwardB_o = FWD_REGFILE;
        if (EXMEM_RegWrite_i && (EXMEM_Rd_i != '0) && (EXMEM_Rd_i == IDEX_Rs_i)) begin
            ForwardA_o = FWD_EXMEM;
        end else if (wb_wr_en && (WBReg_i == IDEX_Rs_i)) begin
            ForwardA_o = FWD_MEMWB;
        end
        if (EXMEM_RegWrite_i && (EXMEM_Rd_i != '0) && (EXMEM_Rd_i == IDEX_Rt_i)) begin
            ForwardB_o = FWD_EXMEM;
        end else if (wb_wr_en && (WBReg_i == IDEX_Rt_i)) begin
            ForwardB_o = FWD_MEMWB;
        end
    end

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: forwarding/writeback vector table,
// hand-written reset/commit/bypass sequences and randomized traffic
// compared against an array-based reference model.
`timescale 1ns/1ps
module tb_wb_regfile;

    typedef struct {
        logic        mem;
        logic        rw;
        logic [31:0] rd;
        logic [31:0] alu;
        logic [4:0]  wbreg;
        logic [4:0]  rs_addr;
        logic [4:0]  rt_addr;
        logic        exw;
        logic [4:0]  exrd;
        logic [4:0]  idrs;
        logic [4:0]  idrt;
    } stim_t;

    typedef struct {
        stim_t       s;
        logic [31:0] exp_wb;
        logic [1:0]  exp_fa;
        logic [1:0]  exp_fb;
    } vec_t;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        MemtoReg_i, RegWrite_i, EXMEM_RegWrite_i;
    logic [31:0] ReadData_i, ALU_i;
    logic [4:0]  WBReg_i, RSaddr_i, RTaddr_i, EXMEM_Rd_i, IDEX_Rs_i, IDEX_Rt_i;
    logic [31:0] RSdata_o, RTdata_o, WBdata_o, WrCount_o;
    logic [1:0]  ForwardA_o, ForwardB_o;

    int          check_count = 0;
    int          pass_count  = 0;
    logic [31:0] model_regs [32];
    logic [31:0] model_cnt;
    vec_t        vecs [7];
    stim_t       st;

    wb_regfile dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .MemtoReg_i(MemtoReg_i), .RegWrite_i(RegWrite_i),
        .ReadData_i(ReadData_i), .ALU_i(ALU_i), .WBReg_i(WBReg_i),
        .RSaddr_i(RSaddr_i), .RTaddr_i(RTaddr_i),
        .RSdata_o(RSdata_o), .RTdata_o(RTdata_o), .WBdata_o(WBdata_o),
        .EXMEM_RegWrite_i(EXMEM_RegWrite_i), .EXMEM_Rd_i(EXMEM_Rd_i),
        .IDEX_Rs_i(IDEX_Rs_i), .IDEX_Rt_i(IDEX_Rt_i),
        .ForwardA_o(ForwardA_o), .ForwardB_o(ForwardB_o),
        .WrCount_o(WrCount_o)
    );

    always #10 clk_i = ~clk_i;

    // Drive every DUT input from one stimulus record.
    task automatic applyStimulus(input stim_t s);
        MemtoReg_i       = s.mem;
        RegWrite_i       = s.rw;
        ReadData_i       = s.rd;
        ALU_i            = s.alu;
        WBReg_i          = s.wbreg;
        RSaddr_i         = s.rs_addr;
        RTaddr_i         = s.rt_addr;
        EXMEM_RegWrite_i = s.exw;
        EXMEM_Rd_i       = s.exrd;
        IDEX_Rs_i        = s.idrs;
        IDEX_Rt_i        = s.idrt;
    endtask

    // Compare one observed value against the bench's expectation.
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        check_count++;
        if (act === exp) pass_count++;
        else $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic stim_t idleStim();
        stim_t s;
        s = '{1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 5'd0, 5'd0};
        return s;
    endfunction

    function automatic logic [31:0] modelWb(input stim_t s);
        return s.mem ? s.rd : s.alu;
    endfunction

    // Architectural value a read port must see this cycle.
    function automatic logic [31:0] modelRead(input stim_t s, input logic [4:0] a);
        if (a == 0) return 32'h0;
        if (s.rw && s.wbreg != 0 && s.wbreg == a) return modelWb(s);
        return model_regs[a];
    endfunction

    function automatic logic [1:0] modelFwd(input stim_t s, input logic [4:0] src);
        if (s.exw && s.exrd != 0 && s.exrd == src) return 2'b10;
        if (s.rw && s.wbreg != 0 && s.wbreg == src) return 2'b01;
        return 2'b00;
    endfunction

    // Reference commit, applied after the clock edge has been taken.
    task automatic modelCommit(input stim_t s);
        if (s.rw && s.wbreg != 0) begin
            model_regs[s.wbreg] = modelWb(s);
            model_cnt           = model_cnt + 1;
        end
    endtask

    task automatic modelClear();
        for (int i = 0; i < 32; i++) model_regs[i] = 32'h0;
        model_cnt = 32'h0;
    endtask

    function automatic logic [4:0] rndAddr();
        if ($urandom_range(0, 3) != 0) return 5'($urandom_range(0, 7));
        return 5'($urandom_range(0, 31));
    endfunction

    initial begin
        // Power-on reset
        rst_i = 1'b1;
        applyStimulus(idleStim());
        modelClear();
        #1;
        checkOutput("por_count", WrCount_o, 32'h0);
        @(negedge clk_i);
        rst_i = 1'b0;

        // Commit through the ALU path and read back next cycle
        st = idleStim();
        st.rw = 1'b1; st.alu = 32'h0000_1234; st.wbreg = 5'd5;
        applyStimulus(st);
        @(posedge clk_i);
        modelCommit(st);
        @(negedge clk_i);
        st = idleStim(); st.rs_addr = 5'd5;
        applyStimulus(st);
        #1;
        checkOutput("commit_read", RSdata_o, 32'h0000_1234);
        checkOutput("commit_count", WrCount_o, 32'd1);

        // Load path with both read ports bypassing
        st = idleStim();
        st.rw = 1'b1; st.mem = 1'b1; st.rd = 32'hDEAD_BEEF; st.alu = 32'h0BAD_0BAD;
        st.wbreg = 5'd7; st.rs_addr = 5'd7; st.rt_addr = 5'd7;
        applyStimulus(st);
        #1;
        checkOutput("bypass_rs", RSdata_o, 32'hDEAD_BEEF);
        checkOutput("bypass_rt", RTdata_o, 32'hDEAD_BEEF);
        checkOutput("bypass_wb", WBdata_o, 32'hDEAD_BEEF);
        @(posedge clk_i);
        modelCommit(st);

        // Write to r0 is dropped and not counted
        @(negedge clk_i);
        st = idleStim();
        st.rw = 1'b1; st.alu = 32'hFFFF_FFFF; st.wbreg = 5'd0;
        applyStimulus(st);
        #1;
        checkOutput("r0_before", RSdata_o, 32'h0);
        @(posedge clk_i);
        modelCommit(st);
        @(negedge clk_i);
        applyStimulus(idleStim());
        #1;
        checkOutput("r0_after", RSdata_o, 32'h0);
        checkOutput("r0_count", WrCount_o, 32'd2);

        // Forwarding and writeback-select vector table
        vecs[0] = '{'{1'b0, 1'b1, 32'h0, 32'h11, 5'd3, 5'd0, 5'd0, 1'b1, 5'd3, 5'd3, 5'd3}, 32'h11, 2'b10, 2'b10};
        vecs[1] = '{'{1'b1, 1'b1, 32'h22, 32'h33, 5'd3, 5'd0, 5'd0, 1'b0, 5'd3, 5'd3, 5'd3}, 32'h22, 2'b01, 2'b01};
        vecs[2] = '{'{1'b1, 1'b1, 32'h22, 32'h33, 5'd3, 5'd0, 5'd0, 1'b0, 5'd3, 5'd3, 5'd4}, 32'h22, 2'b01, 2'b00};
        vecs[3] = '{'{1'b0, 1'b1, 32'h44, 32'h55, 5'd0, 5'd0, 5'd0, 1'b1, 5'd0, 5'd0, 5'd0}, 32'h55, 2'b00, 2'b00};
        vecs[4] = '{'{1'b0, 1'b1, 32'h66, 32'h77, 5'd6, 5'd0, 5'd0, 1'b1, 5'd5, 5'd6, 5'd5}, 32'h77, 2'b01, 2'b10};
        vecs[5] = '{'{1'b1, 1'b0, 32'h88, 32'h99, 5'd5, 5'd0, 5'd0, 1'b0, 5'd5, 5'd5, 5'd5}, 32'h88, 2'b00, 2'b00};
        vecs[6] = '{'{1'b0, 1'b1, 32'hAA, 32'hBB, 5'd8, 5'd0, 5'd0, 1'b1, 5'd7, 5'd1, 5'd2}, 32'hBB, 2'b00, 2'b00};
        for (int i = 0; i < 7; i++) begin
            @(negedge clk_i);
            applyStimulus(vecs[i].s);
            #1;
            checkOutput($sformatf("vec%0d_wb", i), WBdata_o, vecs[i].exp_wb);
            checkOutput($sformatf("vec%0d_fa", i), {30'h0, ForwardA_o}, {30'h0, vecs[i].exp_fa});
            checkOutput($sformatf("vec%0d_fb", i), {30'h0, ForwardB_o}, {30'h0, vecs[i].exp_fb});
            applyStimulus(idleStim());
        end

        // Randomized traffic against the reference model
        for (int n = 0; n < 300; n++) begin
            @(negedge clk_i);
            st.mem     = 1'($urandom_range(0, 1));
            st.rw      = 1'($urandom_range(0, 1));
            st.rd      = $urandom;
            st.alu     = $urandom;
            st.wbreg   = rndAddr();
            st.rs_addr = rndAddr();
            st.rt_addr = rndAddr();
            st.exw     = 1'($urandom_range(0, 1));
            st.exrd    = rndAddr();
            st.idrs    = rndAddr();
            st.idrt    = rndAddr();
            applyStimulus(st);
            #1;
            checkOutput("rnd_rs", RSdata_o, modelRead(st, st.rs_addr));
            checkOutput("rnd_rt", RTdata_o, modelRead(st, st.rt_addr));
            checkOutput("rnd_wb", WBdata_o, modelWb(st));
            checkOutput("rnd_fa", {30'h0, ForwardA_o}, {30'h0, modelFwd(st, st.idrs)});
            checkOutput("rnd_fb", {30'h0, ForwardB_o}, {30'h0, modelFwd(st, st.idrt)});
            checkOutput("rnd_count", WrCount_o, model_cnt);
            @(posedge clk_i);
            modelCommit(st);
        end

        // Asynchronous reset mid-cycle, no clock edge in between
        @(negedge clk_i);
        applyStimulus(idleStim());
        #2;
        rst_i = 1'b1;
        modelClear();
        #0.1;
        checkOutput("async_count", WrCount_o, 32'h0);
        for (int a = 1; a < 32; a++) begin
            RSaddr_i = 5'(a);
            RTaddr_i = 5'(32 - a);
            #0.1;
            checkOutput($sformatf("async_rs%0d", a), RSdata_o, 32'h0);
            checkOutput($sformatf("async_rt%0d", 32 - a), RTdata_o, 32'h0);
        end
        @(negedge clk_i);
        rst_i = 1'b0;

        // Reset held across an edge that carries a write: the write is lost
        @(negedge clk_i);
        st = idleStim();
        st.rw = 1'b1; st.alu = 32'h55; st.wbreg = 5'd9;
        applyStimulus(st);
        #5;
        rst_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        st = idleStim(); st.rs_addr = 5'd9; st.rt_addr = 5'd9;
        applyStimulus(st);
        #1;
        checkOutput("rstwr_rs", RSdata_o, 32'h0);
        checkOutput("rstwr_rt", RTdata_o, 32'h0);
        checkOutput("rstwr_count", WrCount_o, 32'h0);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
